wb_timer_bank: RTL and testbench
================================

# wb_timer_bank

Parametrised bank of independent counter/timer channels behind a Wishbone slave, the successor to the single free-running user-area counter. Each channel counts up or down against a programmable limit, supports auto-reload or one-shot, latches a sticky terminal-count flag and drives an interrupt and a toggle output to the user GPIO pads. It sits directly on the Caravel user-project Wishbone port (WB MI A), with channel 0 mirrored on the logic analyser.

## Interface
Parameters:
- CHANNELS, 4, number of timer channels, 1..8
- WIDTH, 16, counter width in bits, 8..32

Ports (one clock; reset is synchronous and active-high):
- wb_clk_i  in  1  clock; all state changes on its rising edge
- wb_rst_i  in  1  synchronous active-high reset
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe/cycle/write-enable
- wbs_sel_i  in  4  byte-lane selects
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- la_data_out  out  64  [WIDTH-1:0] = channel 0 COUNT, [32+c] = TC flag of channel c, rest 0
- io_out  out  CHANNELS  per-channel toggle output
- io_oeb  out  CHANNELS  all bits = wb_rst_i
- irq  out  3  irq[0] = OR over c of (TC[c] & IE[c]); irq[2:1] = 0

## Operation
- Register map: channel c at byte offset 0x10*c; wbs_adr_i[3:2] selects register; wbs_adr_i[6:4] selects channel; higher address bits ignored.
- 0x0 CTRL: bit0 EN, bit1 DIR (0 up, 1 down), bit2 ONESHOT, bit3 IE; other bits read 0.
- 0x4 COUNT: current value, writable.
- 0x8 LIMIT: up-mode terminal value; down-mode reload value.
- 0xC STATUS: bit0 TC, sticky; writing 1 clears it, writing 0 has no effect.
- Reset: all CTRL, COUNT, LIMIT, STATUS, and io_out = 0; wbs_ack_o = 0; wbs_dat_o = 0.
- Tick: every cycle while EN = 1.
- Up mode: if COUNT == LIMIT, terminal event and COUNT <= 0; else COUNT <= COUNT+1 (mod 2^WIDTH).
- Down mode: if COUNT == 0, terminal event and COUNT <= LIMIT; else COUNT <= COUNT-1.
- Terminal event: TC <= 1, io_out[c] toggles; if ONESHOT, EN <= 0 (the reload still occurs).
- LIMIT = 0 in up mode: terminal event every tick, COUNT stays 0.
- Byte lanes: a write updates only the selected bytes that lie inside WIDTH (CTRL: lane 0 only); STATUS uses lane 0.
- Channel index >= CHANNELS: reads return 0, writes are ignored, and the access is still acknowledged.

## Timing
- A valid access is wbs_cyc_i & wbs_stb_i.
- wbs_ack_o rises on the edge after a valid access is seen while ack = 0, and is high for exactly one cycle. A held request is acknowledged every second cycle.
- Writes take effect on the same edge that raises ack. The read value is registered on that edge and reflects register state before the edge.
- Write to COUNT in the same cycle as a tick: the write wins, with no increment and no terminal event from the old value.
- Write to CTRL in the same cycle as a one-shot terminal event: the written EN wins; TC is still set.
- STATUS clear in the same cycle as a new terminal event: TC stays 1.
- irq[0] and la_data_out are combinational from registers and change the cycle after the causing edge.
- Reset asserted mid-count or mid-access: all state returns to reset values on that edge, and a pending ack is dropped.

## Structure
- Shared package: register offsets (CTRL/COUNT/LIMIT/STATUS), CTRL bit indices, STATUS bit index.
- Sub-module timer_channel: one channel's registers, tick/terminal logic and toggle output. It is instantiated CHANNELS times with a generate loop.
- Top level: Wishbone decode, ack generation, read mux, irq/LA/IO assembly.

## Test plan
- Reset, then read all registers of channels 0..CHANNELS-1 -> all read 0; ack is one cycle wide; io_oeb goes 0 after reset releases.
- Ch0 LIMIT=3, CTRL=0x9 (EN, up, IE) -> COUNT goes 0,1,2,3,0; TC=1 and irq[0]=1 after the wrap; io_out[0] toggles; writing STATUS=1 clears irq[0].
- Ch1 COUNT=2, LIMIT=5, CTRL=0x7 (EN, down, oneshot) -> COUNT goes 2,1,0,5 then holds 5; EN reads 0; TC=1; irq[0] stays 0 (IE=0).
- Ch2 running up, write COUNT=0x00AB with sel=4'b0001 on the same cycle as a tick -> COUNT = 0x00AB, then 0x00AC next cycle.
- With TC set, write STATUS=1 on the cycle of a new terminal event -> TC reads 1.
- Access channel index CHANNELS (e.g. address 0x40 with CHANNELS=4) -> ack returned, read 0, no channel changes; assert wb_rst_i while ch0 is counting -> COUNT=0, EN=0 on the next edge.

Source files
------------

// File: rtl/wb_timer_bank_pkg.sv
// rtl/wb_timer_bank_pkg.sv - shared register map and bit positions for the timer bank
package wb_timer_bank_pkg;

    // Register select, taken from byte address bits [3:2]
    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_COUNT  = 2'd1,
        REG_LIMIT  = 2'd2,
        REG_STATUS = 2'd3
    } reg_e;

    // CTRL bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_DIR     = 1;
    localparam int CTRL_ONESHOT = 2;
    localparam int CTRL_IE      = 3;

    // STATUS bit positions
    localparam int STATUS_TC = 0;

endpackage

// File: rtl/wb_timer_bank_if.sv
// rtl/wb_timer_bank_if.sv - Wishbone slave signal bundle for the timer bank
interface wb_timer_bank_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_timer_bank_timer_channel.sv
// rtl/wb_timer_bank_timer_channel.sv - one timer channel: registers, tick/terminal logic, toggle output
module timer_channel
    import wb_timer_bank_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  reg_e             wr_reg_i,
    input  logic [31:0]      wr_data_i,
    input  logic [3:0]       wr_sel_i,
    output logic [3:0]       ctrl_o,
    output logic [WIDTH-1:0] count_o,
    output logic [WIDTH-1:0] limit_o,
    output logic             tc_o,
    output logic             toggle_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [3:0]       ctrl_q,   ctrl_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] limit_q,  limit_d;
    logic             tc_q,     tc_d;
    logic             toggle_q, toggle_d;

    logic [WIDTH-1:0] count_wr, limit_wr;
    logic             wr_ctrl, wr_count, wr_limit, wr_status;
    logic             at_term, term_evt;

    // Upper data/lane bits are unused when WIDTH < 32
    logic unused_bits;
    assign unused_bits = ^{wr_data_i, wr_sel_i};

    // Next-state: byte-lane merge, tick/terminal, and write priority over the tick
    always_comb begin
        count_wr = count_q;
        limit_wr = limit_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (wr_sel_i[i/8]) begin
                count_wr[i] = wr_data_i[i];
                limit_wr[i] = wr_data_i[i];
            end
        end

        wr_ctrl   = wr_en_i && (wr_reg_i == REG_CTRL)   && wr_sel_i[0];
        wr_count  = wr_en_i && (wr_reg_i == REG_COUNT);
        wr_limit  = wr_en_i && (wr_reg_i == REG_LIMIT);
        wr_status = wr_en_i && (wr_reg_i == REG_STATUS) && wr_sel_i[0];

        at_term  = ctrl_q[CTRL_DIR] ? (count_q == '0) : (count_q == limit_q);
        // A COUNT write replaces the tick entirely, including its terminal event
        term_evt = ctrl_q[CTRL_EN] && at_term && !wr_count;

        count_d = count_q;
        if (wr_count) begin
            count_d = count_wr;
        end else if (ctrl_q[CTRL_EN]) begin
            if (at_term)
                count_d = ctrl_q[CTRL_DIR] ? limit_q : '0;
            else
                count_d = ctrl_q[CTRL_DIR] ? (count_q - ONE) : (count_q + ONE);
        end

        limit_d = wr_limit ? limit_wr : limit_q;

        // Written EN beats the one-shot auto-disable
        ctrl_d = ctrl_q;
        if (term_evt && ctrl_q[CTRL_ONESHOT])
            ctrl_d[CTRL_EN] = 1'b0;
        if (wr_ctrl)
            ctrl_d = wr_data_i[3:0];

        // A new terminal event beats a same-cycle clear
        tc_d = tc_q;
        if (wr_status && wr_data_i[STATUS_TC])
            tc_d = 1'b0;
        if (term_evt)
            tc_d = 1'b1;

        toggle_d = toggle_q ^ term_evt;
    end

    // Channel state registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q   <= '0;
            count_q  <= '0;
            limit_q  <= '0;
            tc_q     <= 1'b0;
            toggle_q <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            count_q  <= count_d;
            limit_q  <= limit_d;
            tc_q     <= tc_d;
            toggle_q <= toggle_d;
        end
    end

    assign ctrl_o   = ctrl_q;
    assign count_o  = count_q;
    assign limit_o  = limit_q;
    assign tc_o     = tc_q;
    assign toggle_o = toggle_q;

endmodule

// File: rtl/wb_timer_bank.sv
// rtl/wb_timer_bank.sv - Wishbone-attached bank of timer channels with irq, LA and IO outputs
module wb_timer_bank
    import wb_timer_bank_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    wb_timer_bank_if.slave      wbs,
    output logic [63:0]         la_data_out,
    output logic [CHANNELS-1:0] io_out,
    output logic [CHANNELS-1:0] io_oeb,
    output logic [2:0]          irq
);

    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        access, wr_access;
    logic [2:0]  chan;
    reg_e        rsel;
    logic [31:0] rdata;

    logic [3:0]          ctrl_w  [CHANNELS];
    logic [WIDTH-1:0]    count_w [CHANNELS];
    logic [WIDTH-1:0]    limit_w [CHANNELS];
    logic [CHANNELS-1:0] tc_w, tog_w, ie_w;

    logic unused_adr;
    assign unused_adr = ^{wbs.wbs_adr_i[31:7], wbs.wbs_adr_i[1:0]};

    assign chan      = wbs.wbs_adr_i[6:4];
    assign rsel      = reg_e'(wbs.wbs_adr_i[3:2]);
    // A held request is only taken while ack is low, giving one ack every second cycle
    assign access    = wbs.wbs_cyc_i && wbs.wbs_stb_i && !ack_q;
    assign wr_access = access && wbs.wbs_we_i;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        timer_channel #(.WIDTH(WIDTH)) u_ch (
            .clk_i     (wb_clk_i),
            .rst_i     (wb_rst_i),
            .wr_en_i   (wr_access && (chan == 3'(c))),
            .wr_reg_i  (rsel),
            .wr_data_i (wbs.wbs_dat_i),
            .wr_sel_i  (wbs.wbs_sel_i),
            .ctrl_o    (ctrl_w[c]),
            .count_o   (count_w[c]),
            .limit_o   (limit_w[c]),
            .tc_o      (tc_w[c]),
            .toggle_o  (tog_w[c])
        );
        assign ie_w[c] = ctrl_w[c][CTRL_IE];
    end

    // Read mux; unpopulated channel indices read as zero
    always_comb begin
        rdata = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (chan == 3'(c)) begin
                case (rsel)
                    REG_CTRL:   rdata[3:0]       = ctrl_w[c];
                    REG_COUNT:  rdata[WIDTH-1:0] = count_w[c];
                    REG_LIMIT:  rdata[WIDTH-1:0] = limit_w[c];
                    REG_STATUS: rdata[STATUS_TC] = tc_w[c];
                    default:    rdata            = '0;
                endcase
            end
        end
        ack_d = access;
        dat_d = (access && !wbs.wbs_we_i) ? rdata : dat_q;
    end

    // Ack and registered read data
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= ack_d;
            dat_q <= dat_d;
        end
    end

    // Logic analyser view: channel 0 count plus all TC flags
    always_comb begin
        la_data_out = '0;
        la_data_out[WIDTH-1:0] = count_w[0];
        for (int c = 0; c < CHANNELS; c++)
            la_data_out[32+c] = tc_w[c];
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign io_out        = tog_w;
    assign io_oeb        = {CHANNELS{wb_rst_i}};
    assign irq           = {2'b00, |(tc_w & ie_w)};

endmodule

// File: tb/tb_wb_timer_bank.sv
// tb/tb_wb_timer_bank.sv - directed self-checking bench for wb_timer_bank
module tb_wb_timer_bank;

    logic        clk;
    logic        rst;
    logic [63:0] la;
    logic [3:0]  io_out;
    logic [3:0]  io_oeb;
    logic [2:0]  irq;

    int compared   = 0;
    int mismatched = 0;

    wb_timer_bank_if bus ();

    wb_timer_bank #(.CHANNELS(4), .WIDTH(16)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs         (bus),
        .la_data_out (la),
        .io_out      (io_out),
        .io_oeb      (io_oeb),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wb_access(input string tag, input logic [31:0] adr, input logic we,
                             input logic [31:0] data, input logic [3:0] sel,
                             output logic [31:0] rd);
        logic got;
        bus.wbs_adr_i = adr;
        bus.wbs_we_i  = we;
        bus.wbs_dat_i = data;
        bus.wbs_sel_i = sel;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            @(posedge clk);
            #1;
            if (bus.wbs_ack_o) got = 1'b1;
        end
        rd = bus.wbs_dat_o;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        chk({tag, "_ack"}, 64'(got), 64'd1);
    endtask

    task automatic wr(input string tag, input logic [31:0] adr, input logic [31:0] data,
                      input logic [3:0] sel);
        logic [31:0] dummy;
        wb_access(tag, adr, 1'b1, data, sel, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] v;
        wb_access(tag, adr, 1'b0, 32'h0, 4'hF, v);
        chk(tag, 64'(v), 64'(exp));
    endtask

    // Bounded wait for the ch0 count on the LA port
    task automatic wait_cnt0(input string tag, input logic [15:0] val);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (la[15:0] == val) seen = 1'b1;
        end
        chk(tag, 64'(seen), 64'd1);
    endtask

    task automatic wait_irq(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (irq[0]) seen = 1'b1;
        end
        chk(tag, 64'(seen), 64'd1);
    endtask

    logic [15:0] seq_up [4];

    initial begin
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = 32'h0;
        bus.wbs_dat_i = 32'h0;
        rst = 1'b1;
        seq_up[0] = 16'd1; seq_up[1] = 16'd2; seq_up[2] = 16'd3; seq_up[3] = 16'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack",    64'(bus.wbs_ack_o), 64'd0);
        chk("rst_dat",    64'(bus.wbs_dat_o), 64'd0);
        chk("rst_oeb",    64'(io_oeb), 64'hF);
        chk("rst_la",     la, 64'd0);
        chk("rst_irq",    64'(irq), 64'd0);
        chk("rst_io_out", 64'(io_out), 64'd0);
        rst = 1'b0;
        #1;
        chk("oeb_release", 64'(io_oeb), 64'h0);

        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                rd_chk($sformatf("rst_rd_c%0d_r%0d", c, r), 32'(c * 16 + r * 4), 32'h0);
        @(posedge clk);
        #1;
        chk("ack_one_cycle", 64'(bus.wbs_ack_o), 64'd0);

        // Ch1 one-shot down count: 2,1,0 -> reload 5, then stop
        wr("c1_count", 32'h14, 32'd2, 4'hF);
        wr("c1_limit", 32'h18, 32'd5, 4'hF);
        wr("c1_ctrl",  32'h10, 32'h7, 4'hF);
        repeat (6) @(posedge clk);
        #1;
        chk("c1_irq_masked", 64'(irq), 64'd0);
        chk("c1_io_out",     64'(io_out), 64'b0010);
        rd_chk("c1_count_hold", 32'h14, 32'd5);
        rd_chk("c1_ctrl_en0",   32'h10, 32'h6);
        rd_chk("c1_status_tc",  32'h1C, 32'h1);

        // Ch0 up count with LIMIT=3 and IE, watched on the LA port
        wr("c0_limit", 32'h08, 32'd3, 4'hF);
        wr("c0_ctrl",  32'h00, 32'h9, 4'hF);
        chk("c0_cnt_start", 64'(la[15:0]), 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("c0_cnt_%0d", k), 64'(la[15:0]), 64'(seq_up[k]));
            chk($sformatf("c0_irq_%0d", k), 64'(irq[0]), (k == 3) ? 64'd1 : 64'd0);
        end
        chk("c0_la_tc",  64'(la[32]), 64'd1);
        chk("c0_io_out", 64'(io_out), 64'b0011);
        wr("c0_clear", 32'h0C, 32'h1, 4'h1);
        chk("c0_irq_cleared", 64'(irq), 64'd0);
        chk("c0_la_tc_clr",   64'(la[32]), 64'd0);

        // Clear on the same edge as a fresh terminal event: TC must stay set
        wait_irq("c0_tc_again");
        wait_cnt0("c0_reach3", 16'd3);
        wr("c0_clear_race", 32'h0C, 32'h1, 4'h1);
        chk("c0_race_tc",  64'(la[32]), 64'd1);
        chk("c0_race_irq", 64'(irq[0]), 64'd1);

        // Ch2 running up; lane-0 COUNT write on a tick cycle wins over the increment
        wr("c2_limit", 32'h28, 32'hFFFF, 4'hF);
        wr("c2_ctrl",  32'h20, 32'h1, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        wr("c2_count", 32'h24, 32'h12AB, 4'b0001);
        rd_chk("c2_count_after", 32'h24, 32'h00AC);

        // Unpopulated channel index 4
        wr("oor_ctrl_wr", 32'h40, 32'h0, 4'hF);
        rd_chk("oor_ctrl_rd", 32'h40, 32'h0);
        wr("oor_count_wr", 32'h44, 32'h1234, 4'hF);
        rd_chk("oor_count_rd", 32'h44, 32'h0);
        rd_chk("oor_c0_ctrl",  32'h00, 32'h9);
        rd_chk("oor_c1_count", 32'h14, 32'd5);

        // Reset while ch0 counts and a read is pending
        wait_cnt0("pre_rst_cnt", 16'd1);
        bus.wbs_adr_i = 32'h04;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'hF;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_ack",    64'(bus.wbs_ack_o), 64'd0);
        chk("mid_rst_la",     la, 64'd0);
        chk("mid_rst_irq",    64'(irq), 64'd0);
        chk("mid_rst_io_out", 64'(io_out), 64'd0);
        chk("mid_rst_oeb",    64'(io_oeb), 64'hF);
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_la", la, 64'd0);
        rd_chk("post_rst_c0_ctrl",  32'h00, 32'h0);
        rd_chk("post_rst_c1_count", 32'h14, 32'h0);
        rd_chk("post_rst_c0_limit", 32'h08, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
